id_hazard_stage: RTL and testbench

Parametrised instruction-decode stage for the pipelined MIPS core, with a built-in ID/EX pipeline register and hazard detection. It decodes the opcode into control bits and reads an internal register file. It forwards EX/MEM/WB results into the operands and resolves `beq`/`bne` in ID. It detects load-use hazards and inserts bubbles. It sits between the IF/ID register and the EX stage.

---
 rtl/id_hazard_stage.sv | 242 ++++++++++++++++++++++++
 tb/tb_id_hazard_stage.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_stage.sv
// Instruction-decode stage: control decode, register file, EX/MEM/WB operand
// forwarding, in-ID beq/bne resolution, load-use stall and the ID/EX register.
module id_hazard_stage #(
  parameter int REG_WIDTH      = 8,
  parameter int REG_FILE_DEPTH = 8,
  parameter int REG_DIR_WIDTH  = 3,
  parameter int IMM_IN_WIDTH   = 6,
  parameter int PC_WIDTH       = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              instr,
  input  logic [PC_WIDTH-1:0]      pc_next,
  input  logic                     idex_flush,
  input  logic                     wb_reg_write,
  input  logic [REG_DIR_WIDTH-1:0] wb_reg,
  input  logic [REG_WIDTH-1:0]     wb_data,
  input  logic [REG_WIDTH-1:0]     ex_alu_result,
  input  logic                     exmem_reg_write,
  input  logic [REG_DIR_WIDTH-1:0] exmem_reg,
  input  logic [REG_WIDTH-1:0]     mem_fwd_data,
  output logic                     stall,
  output logic                     if_flush,
  output logic [PC_WIDTH-1:0]      branch_target,
  output logic [7:0]               idex_ctrl,
  output logic [REG_WIDTH-1:0]     idex_rd1,
  output logic [REG_WIDTH-1:0]     idex_rd2,
  output logic [REG_WIDTH-1:0]     idex_imm,
  output logic [REG_DIR_WIDTH-1:0] idex_rs,
  output logic [REG_DIR_WIDTH-1:0] idex_rt,
  output logic [REG_DIR_WIDTH-1:0] idex_rd
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [5:0]              op;
  logic [REG_DIR_WIDTH-1:0] rs;
  logic [REG_DIR_WIDTH-1:0] rt;
  logic [REG_DIR_WIDTH-1:0] rd;
  logic [IMM_IN_WIDTH-1:0] imm_raw;
  logic [31:0]             imm_sext;

  assign op       = instr[31:26];
  assign rs       = instr[21 +: REG_DIR_WIDTH];
  assign rt       = instr[16 +: REG_DIR_WIDTH];
  assign rd       = instr[11 +: REG_DIR_WIDTH];
  assign imm_raw  = instr[IMM_IN_WIDTH-1:0];
  assign imm_sext = {{(32-IMM_IN_WIDTH){imm_raw[IMM_IN_WIDTH-1]}}, imm_raw};

  // Bits that no field consumes under the current parameters.
  logic unused_bits;
  assign unused_bits = ^{instr, imm_sext};

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  ctrl_t ctrl_dec;
  logic  is_branch;
  logic  is_bne;
  logic  uses_rt;

  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path through the case leaves it unassigned and infers a latch.
    ctrl_dec  = '0;
    is_branch = 1'b0;
    is_bne    = 1'b0;
    uses_rt   = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl_dec = '{reg_write: 1'b1, mem_to_reg: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                     alu_src: 1'b0, reg_dst: 1'b1, alu_op: 2'b10};
        uses_rt  = 1'b1;
      end
      OP_LW: begin
        ctrl_dec = '{reg_write: 1'b1, mem_to_reg: 1'b1, mem_read: 1'b1, mem_write: 1'b0,
                     alu_src: 1'b1, reg_dst: 1'b0, alu_op: 2'b00};
      end
      OP_SW: begin
        ctrl_dec = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_read: 1'b0, mem_write: 1'b1,
                     alu_src: 1'b1, reg_dst: 1'b0, alu_op: 2'b00};
        uses_rt  = 1'b1;
      end
      OP_ADDI: begin
        ctrl_dec = '{reg_write: 1'b1, mem_to_reg: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                     alu_src: 1'b1, reg_dst: 1'b0, alu_op: 2'b00};
      end
      OP_BEQ, OP_BNE: begin
        ctrl_dec.alu_op = 2'b01;
        is_branch       = 1'b1;
        is_bne          = (op == OP_BNE);
        uses_rt         = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [REG_WIDTH-1:0] regs_q [REG_FILE_DEPTH];
  logic                 rf_we;

  assign rf_we = wb_reg_write && (wb_reg != '0) && (int'(wb_reg) < REG_FILE_DEPTH);

  // NOTE: the register file is small and must read as zero out of reset, so it
  // is reset like any other state rather than left as an uninitialised RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_FILE_DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (rf_we) begin
      regs_q[wb_reg] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // ID/EX register state
  // ---------------------------------------------------------------------------
  ctrl_t                    ctrl_q,  ctrl_d;
  logic [REG_WIDTH-1:0]     rd1_q,   rd1_d;
  logic [REG_WIDTH-1:0]     rd2_q,   rd2_d;
  logic [REG_WIDTH-1:0]     imm_q,   imm_d;
  logic [REG_DIR_WIDTH-1:0] rs_q,    rs_d;
  logic [REG_DIR_WIDTH-1:0] rt_q,    rt_d;
  logic [REG_DIR_WIDTH-1:0] rd_q,    rd_d;

  // ---------------------------------------------------------------------------
  // Operand forwarding: r0, EX, MEM, WB, then register file
  // ---------------------------------------------------------------------------
  logic [REG_DIR_WIDTH-1:0] ex_dest;
  logic                     ex_fwd_en;
  logic [REG_DIR_WIDTH-1:0] src  [2];
  logic [REG_WIDTH-1:0]     opnd [2];

  assign ex_dest   = ctrl_q.reg_dst ? rd_q : rt_q;
  // A load in EX has no result yet; the stall logic covers that case.
  assign ex_fwd_en = ctrl_q.reg_write && !ctrl_q.mem_read;
  assign src[0]    = rs;
  assign src[1]    = rt;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      opnd[i] = '0;
      if (src[i] == '0) begin
        opnd[i] = '0;
      end else if (ex_fwd_en && (ex_dest == src[i])) begin
        opnd[i] = ex_alu_result;
      end else if (exmem_reg_write && (exmem_reg == src[i])) begin
        opnd[i] = mem_fwd_data;
      end else if (wb_reg_write && (wb_reg == src[i])) begin
        opnd[i] = wb_data;
      end else if (int'(src[i]) < REG_FILE_DEPTH) begin
        opnd[i] = regs_q[src[i]];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard and branch resolution
  // ---------------------------------------------------------------------------
  logic ops_equal;
  logic ex_bubble;

  assign stall = ctrl_q.mem_read && (rt_q != '0) &&
                 ((rt_q == rs) || ((rt_q == rt) && uses_rt));

  assign ops_equal     = (opnd[0] == opnd[1]);
  assign if_flush      = is_branch && !stall && (is_bne ? !ops_equal : ops_equal);
  assign branch_target = pc_next + imm_sext[PC_WIDTH-1:0];

  assign ex_bubble = stall || idex_flush;

  always_comb begin
    ctrl_d = '0;
    rd1_d  = '0;
    rd2_d  = '0;
    imm_d  = '0;
    rs_d   = '0;
    rt_d   = '0;
    rd_d   = '0;
    if (!ex_bubble) begin
      ctrl_d = ctrl_dec;
      rd1_d  = opnd[0];
      rd2_d  = opnd[1];
      imm_d  = imm_sext[REG_WIDTH-1:0];
      rs_d   = rs;
      rt_d   = rt;
      rd_d   = rd;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
    end
  end

  assign idex_ctrl = ctrl_q;
  assign idex_rd1  = rd1_q;
  assign idex_rd2  = rd2_q;
  assign idex_imm  = imm_q;
  assign idex_rs   = rs_q;
  assign idex_rt   = rt_q;
  assign idex_rd   = rd_q;

endmodule

// File: tb/tb_id_hazard_stage.sv
// Self-checking bench for id_hazard_stage: directed scenarios plus randomized
// traffic checked against a behavioural model of the decode stage.
module tb_id_hazard_stage;

  localparam int RW = 8;
  localparam int RD = 8;
  localparam int AW = 3;
  localparam int PW = 6;
  localparam logic [31:0] NOP = 32'hFC00_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr;
  logic [PW-1:0] pc_next;
  logic          idex_flush;
  logic          wb_reg_write;
  logic [AW-1:0] wb_reg;
  logic [RW-1:0] wb_data;
  logic [RW-1:0] ex_alu_result;
  logic          exmem_reg_write;
  logic [AW-1:0] exmem_reg;
  logic [RW-1:0] mem_fwd_data;
  logic          stall;
  logic          if_flush;
  logic [PW-1:0] branch_target;
  logic [7:0]    idex_ctrl;
  logic [RW-1:0] idex_rd1, idex_rd2, idex_imm;
  logic [AW-1:0] idex_rs, idex_rt, idex_rd;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state: what the DUT's ID/EX register and RF should hold.
  logic [RW-1:0] m_rf [RD];
  logic [7:0]    m_ctrl;
  logic [RW-1:0] m_rd1, m_rd2, m_imm;
  logic [AW-1:0] m_rs, m_rt, m_rd;

  id_hazard_stage dut (
    .clk             (clk),
    .rst             (rst),
    .instr           (instr),
    .pc_next         (pc_next),
    .idex_flush      (idex_flush),
    .wb_reg_write    (wb_reg_write),
    .wb_reg          (wb_reg),
    .wb_data         (wb_data),
    .ex_alu_result   (ex_alu_result),
    .exmem_reg_write (exmem_reg_write),
    .exmem_reg       (exmem_reg),
    .mem_fwd_data    (mem_fwd_data),
    .stall           (stall),
    .if_flush        (if_flush),
    .branch_target   (branch_target),
    .idex_ctrl       (idex_ctrl),
    .idex_rd1        (idex_rd1),
    .idex_rd2        (idex_rd2),
    .idex_imm        (idex_imm),
    .idex_rs         (idex_rs),
    .idex_rt         (idex_rt),
    .idex_rd         (idex_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input int s, input int t,
                                     input int d, input logic [5:0] imm);
    return {op, 5'(s), 5'(t), 5'(d), 5'd0, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    instr           = NOP;
    pc_next         = '0;
    idex_flush      = 1'b0;
    wb_reg_write    = 1'b0;
    wb_reg          = '0;
    wb_data         = '0;
    ex_alu_result   = '0;
    exmem_reg_write = 1'b0;
    exmem_reg       = '0;
    mem_fwd_data    = '0;
  endtask

  task automatic bubble();
    idle();
    idex_flush = 1'b1;
    tick();
    idex_flush = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [58:0] all_idex;
    idle();
    rst = 1'b0;
    #3;
    all_idex = {idex_ctrl, idex_rd1, idex_rd2, idex_imm, idex_rs, idex_rt, idex_rd};
    checks++;
    if (all_idex !== '0) begin
      failures++; $display("FAIL reset_initial got=%h exp=0", all_idex);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    for (int i = 1; i < 8; i++) begin
      wb_reg_write = 1'b1; wb_reg = AW'(i); wb_data = RW'(16 * i + 1);
      tick();
    end
    idle();
    instr = mk(6'h00, 5, 0, 0, 6'h20);
    tick();
    checks++;
    if (idex_rd1 !== 8'h51) begin
      failures++; $display("FAIL reset_pre_rf_r5 got=%h exp=51", idex_rd1);
    end
    #2 rst = 1'b0;
    #1;
    all_idex = {idex_ctrl, idex_rd1, idex_rd2, idex_imm, idex_rs, idex_rt, idex_rd};
    checks++;
    if (all_idex !== '0) begin
      failures++; $display("FAIL reset_async_clear got=%h exp=0", all_idex);
    end
    #1 rst = 1'b1;
    for (int i = 1; i < 8; i++) begin
      instr = mk(6'h00, i, 0, 0, 6'h20);
      tick();
      checks++;
      if (idex_rd1 !== '0) begin
        failures++; $display("FAIL reset_rf_r%0d got=%h exp=00", i, idex_rd1);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wb_bypass();
    bubble();
    wb_reg_write = 1'b1; wb_reg = 3'd3; wb_data = 8'h5A;
    instr = mk(6'h00, 3, 0, 4, 6'h20);
    tick();
    checks++;
    if (idex_rd1 !== 8'h5A) begin
      failures++; $display("FAIL wb_bypass_rd1 got=%h exp=5a", idex_rd1);
    end
    checks++;
    if (idex_rd2 !== 8'h00) begin
      failures++; $display("FAIL wb_bypass_rd2 got=%h exp=00", idex_rd2);
    end
    wb_reg = 3'd0; wb_data = 8'hFF;
    instr = mk(6'h00, 0, 0, 4, 6'h20);
    tick();
    checks++;
    if (idex_rd1 !== 8'h00) begin
      failures++; $display("FAIL wb_r0_write got=%h exp=00", idex_rd1);
    end
    idle();
    instr = mk(6'h00, 3, 0, 0, 6'h20);
    tick();
    checks++;
    if (idex_rd1 !== 8'h5A) begin
      failures++; $display("FAIL wb_rf_r3 got=%h exp=5a", idex_rd1);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_use();
    bubble();
    instr = mk(6'h23, 0, 2, 0, 6'h00);
    tick();
    checks++;
    if (idex_ctrl !== 8'hE8) begin
      failures++; $display("FAIL lu_lw_ctrl got=%h exp=e8", idex_ctrl);
    end
    instr = mk(6'h00, 2, 1, 5, 6'h20);
    settle();
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL lu_stall got=%b exp=1", stall);
    end
    tick();
    checks++;
    if (idex_ctrl !== 8'h00) begin
      failures++; $display("FAIL lu_bubble_ctrl got=%h exp=00", idex_ctrl);
    end
    exmem_reg_write = 1'b1; exmem_reg = 3'd2; mem_fwd_data = 8'h33;
    settle();
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL lu_stall_one_cycle got=%b exp=0", stall);
    end
    tick();
    checks++;
    if (idex_rd1 !== 8'h33) begin
      failures++; $display("FAIL lu_mem_fwd got=%h exp=33", idex_rd1);
    end
    checks++;
    if (idex_ctrl !== 8'h86) begin
      failures++; $display("FAIL lu_add_ctrl got=%h exp=86", idex_ctrl);
    end
    // rt of addi is a destination, so a match there is not a hazard; sw reads rt.
    bubble();
    instr = mk(6'h23, 0, 2, 0, 6'h00);
    tick();
    instr = mk(6'h08, 0, 2, 0, 6'h01);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++; $display("FAIL lu_addi_no_stall got=%b exp=0", stall);
    end
    instr = mk(6'h2B, 0, 2, 0, 6'h00);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL lu_sw_stall got=%b exp=1", stall);
    end
    tick();
    bubble();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_branch();
    bubble();
    wb_reg_write = 1'b1; wb_reg = 3'd2; wb_data = 8'h10;
    instr = mk(6'h08, 0, 1, 0, 6'h05);
    tick();
    idle();
    ex_alu_result = 8'h10;
    pc_next = 6'd6;
    instr = mk(6'h04, 1, 2, 0, 6'h3E);
    settle();
    checks++;
    if (if_flush !== 1'b1) begin
      failures++; $display("FAIL beq_taken got=%b exp=1", if_flush);
    end
    checks++;
    if (branch_target !== 6'd4) begin
      failures++; $display("FAIL beq_target got=%0d exp=4", branch_target);
    end
    instr = mk(6'h05, 1, 2, 0, 6'h3E);
    #1;
    checks++;
    if (if_flush !== 1'b0) begin
      failures++; $display("FAIL bne_not_taken got=%b exp=0", if_flush);
    end
    instr = mk(6'h04, 1, 2, 0, 6'h3E);
    idex_flush = 1'b1;
    #1;
    checks++;
    if (if_flush !== 1'b1) begin
      failures++; $display("FAIL beq_with_flush got=%b exp=1", if_flush);
    end
    tick();
    idex_flush = 1'b0;
    bubble();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_priority();
    bubble();
    instr = mk(6'h08, 0, 1, 0, 6'h05);
    tick();
    ex_alu_result = 8'h11;
    exmem_reg_write = 1'b1; exmem_reg = 3'd1; mem_fwd_data = 8'h22;
    instr = mk(6'h00, 1, 0, 6, 6'h20);
    tick();
    checks++;
    if (idex_rd1 !== 8'h11) begin
      failures++; $display("FAIL prio_ex_over_mem got=%h exp=11", idex_rd1);
    end
    wb_reg_write = 1'b1; wb_reg = 3'd1; wb_data = 8'h44;
    tick();
    checks++;
    if (idex_rd1 !== 8'h22) begin
      failures++; $display("FAIL prio_mem_over_wb got=%h exp=22", idex_rd1);
    end
    bubble();
    instr = mk(6'h00, 1, 0, 6, 6'h20);
    tick();
    checks++;
    if (idex_rd1 !== 8'h44) begin
      failures++; $display("FAIL prio_rf_r1 got=%h exp=44", idex_rd1);
    end
    bubble();
    instr = mk(6'h23, 0, 1, 0, 6'h00);
    tick();
    ex_alu_result = 8'h11;
    exmem_reg_write = 1'b1; exmem_reg = 3'd1; mem_fwd_data = 8'h22;
    instr = mk(6'h00, 1, 0, 6, 6'h20);
    settle();
    checks++;
    if (stall !== 1'b1) begin
      failures++; $display("FAIL prio_ex_load_stall got=%b exp=1", stall);
    end
    tick();
    bubble();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    bubble();
    idex_flush = 1'b1;
    instr = mk(6'h08, 0, 1, 0, 6'h05);
    tick();
    checks++;
    if (idex_ctrl !== 8'h00) begin
      failures++; $display("FAIL flush_ctrl got=%h exp=00", idex_ctrl);
    end
    checks++;
    if (idex_rt !== 3'd0) begin
      failures++; $display("FAIL flush_rt got=%0d exp=0", idex_rt);
    end
    idex_flush = 1'b0;
    pc_next = 6'd63;
    instr = mk(6'h04, 0, 0, 0, 6'h02);
    #1;
    checks++;
    if (branch_target !== 6'd1) begin
      failures++; $display("FAIL target_wrap_up got=%0d exp=1", branch_target);
    end
    pc_next = 6'd1;
    instr = mk(6'h04, 0, 0, 0, 6'h3E);
    #1;
    checks++;
    if (branch_target !== 6'd63) begin
      failures++; $display("FAIL target_wrap_down got=%0d exp=63", branch_target);
    end
    bubble();
  endtask

  // ---------------------------------------------------------------------------
  function automatic logic [7:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'h00:        return 8'b1000_0110;
      6'h23:        return 8'b1110_1000;
      6'h2B:        return 8'b0001_1000;
      6'h08:        return 8'b1000_1000;
      6'h04, 6'h05: return 8'b0000_0001;
      default:      return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [RW-1:0] ref_operand(input logic [AW-1:0] r);
    logic [AW-1:0] ex_dst;
    ex_dst = m_ctrl[2] ? m_rd : m_rt;
    if (r == 0) return '0;
    if (m_ctrl[7] && !m_ctrl[5] && ex_dst == r) return ex_alu_result;
    if (exmem_reg_write && exmem_reg == r) return mem_fwd_data;
    if (wb_reg_write && wb_reg == r) return wb_data;
    if (int'(r) < RD) return m_rf[r];
    return '0;
  endfunction

  function automatic logic [RW-1:0] pick_data();
    case ($urandom_range(0, 3))
      0:       return 8'h10;
      1:       return 8'h20;
      2:       return 8'h33;
      default: return RW'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic [5:0]    ops [7];
    logic [5:0]    op;
    logic [AW-1:0] s, t, d;
    logic [RW-1:0] a, b;
    logic signed [5:0] imm6;
    int            immv;
    logic          e_stall, e_taken, is_br, reads_rt;
    logic [PW-1:0] e_target;
    logic [7:0]    n_ctrl;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h3F};
    idle();
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    for (int i = 0; i < RD; i++) m_rf[i] = '0;
    m_ctrl = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_rs = '0; m_rt = '0; m_rd = '0;
    for (int n = 0; n < 400; n++) begin
      op              = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      instr           = {op, 26'($urandom)};
      pc_next         = PW'($urandom);
      idex_flush      = ($urandom_range(0, 7) == 0);
      wb_reg_write    = $urandom_range(0, 1) == 1;
      wb_reg          = AW'($urandom);
      wb_data         = pick_data();
      ex_alu_result   = pick_data();
      exmem_reg_write = $urandom_range(0, 1) == 1;
      exmem_reg       = AW'($urandom);
      mem_fwd_data    = pick_data();
      settle();
      s = instr[23:21]; t = instr[18:16]; d = instr[13:11];
      imm6 = instr[5:0];
      immv = int'(imm6);
      a = ref_operand(s);
      b = ref_operand(t);
      is_br    = (op == 6'h04) || (op == 6'h05);
      reads_rt = (op == 6'h00) || (op == 6'h2B) || is_br;
      e_stall  = m_ctrl[5] && (m_rt != 0) && ((m_rt == s) || (reads_rt && m_rt == t));
      e_taken  = is_br && !e_stall && ((op == 6'h04) ? (a == b) : (a != b));
      e_target = PW'((int'(pc_next) + immv + 64) % 64);
      n_ctrl   = ref_ctrl(op);
      checks++;
      if (stall !== e_stall) begin
        failures++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", n, stall, e_stall);
      end
      checks++;
      if (if_flush !== e_taken) begin
        failures++; $display("FAIL rnd_if_flush cyc=%0d got=%b exp=%b", n, if_flush, e_taken);
      end
      checks++;
      if (branch_target !== e_target) begin
        failures++; $display("FAIL rnd_target cyc=%0d got=%0d exp=%0d", n, branch_target, e_target);
      end
      tick();
      if (e_stall || idex_flush) begin
        m_ctrl = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_rs = '0; m_rt = '0; m_rd = '0;
      end else begin
        m_ctrl = n_ctrl; m_rd1 = a; m_rd2 = b; m_imm = RW'(immv);
        m_rs = s; m_rt = t; m_rd = d;
      end
      if (wb_reg_write && wb_reg != 0 && int'(wb_reg) < RD) m_rf[wb_reg] = wb_data;
      checks++;
      if (idex_ctrl !== m_ctrl) begin
        failures++; $display("FAIL rnd_ctrl cyc=%0d got=%h exp=%h", n, idex_ctrl, m_ctrl);
      end
      checks++;
      if ({idex_rd1, idex_rd2} !== {m_rd1, m_rd2}) begin
        failures++;
        $display("FAIL rnd_operands cyc=%0d got=%h/%h exp=%h/%h", n, idex_rd1, idex_rd2, m_rd1, m_rd2);
      end
      checks++;
      if ({idex_imm, idex_rs, idex_rt, idex_rd} !== {m_imm, m_rs, m_rt, m_rd}) begin
        failures++;
        $display("FAIL rnd_fields cyc=%0d got=%h/%0d/%0d/%0d exp=%h/%0d/%0d/%0d", n,
                 idex_imm, idex_rs, idex_rt, idex_rd, m_imm, m_rs, m_rt, m_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wb_bypass();
    test_load_use();
    test_branch();
    test_priority();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
